// File: rtl/timer_bank.sv
// Multi-channel memory-mapped down-counter timer for the picorv32 native bus.
// Each channel: prescaler, periodic/one-shot reload, sticky pending flag, masked irq.
module timer_bank #(
  parameter int CHANNELS    = 4,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                select,
  input  logic [3:0]          wstrb,
  input  logic [6:0]          addr,
  input  logic [31:0]         data_i,
  output logic                ready,
  output logic [31:0]         data_o,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any
);

  localparam int PW = PRESC_WIDTH;

  logic [CHANNELS-1:0] en, mode, ie, pending;
  logic [PW-1:0]       presc [CHANNELS];
  logic [PW-1:0]       pc    [CHANNELS];
  logic [31:0]         load  [CHANNELS];
  logic [31:0]         value [CHANNELS];

  // Handshake: an access is taken at any rising edge with select=1 and ready=0;
  // ready is the registered copy of that condition, so it pulses for exactly one
  // cycle and a select held high cannot retrigger while ready is up.
  logic       access, wr;
  logic [2:0] ch_idx;
  logic [1:0] reg_sel;
  wire        unused_addr = ^addr[1:0];

  assign access  = select & ~ready;
  assign wr      = access & (|wstrb);
  assign ch_idx  = addr[6:4];
  assign reg_sel = addr[3:2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [CHANNELS-1:0] ctrl_wr, load_wr, value_wr, clear, tick, expire, en_new;
  logic [PW-1:0]       presc_new [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ctrl_wr[c]  = wr && (ch_idx == 3'(c)) && (reg_sel == 2'd0);
      load_wr[c]  = wr && (ch_idx == 3'(c)) && (reg_sel == 2'd1);
      value_wr[c] = wr && (ch_idx == 3'(c)) && (reg_sel == 2'd2);
      clear[c]    = wr && (ch_idx == 3'(c)) && (reg_sel == 2'd3) && wstrb[0] && data_i[0];
      tick[c]     = en[c] && (pc[c] == presc[c]);
      // A VALUE write in the same cycle overrides both decrement and expiry.
      expire[c]   = tick[c] && (value[c] == 32'd0) && !value_wr[c];
      en_new[c]   = wstrb[0] ? data_i[0] : en[c];
      for (int i = 0; i < PW; i++)
        presc_new[c][i] = wstrb[2 + i/8] ? data_i[16 + i] : presc[c][i];
    end
  end

  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_idx == 3'(c)) begin
        case (reg_sel)
          2'd0: begin
            rd_data            = 32'({ie[c], mode[c], en[c]});
            rd_data[16 +: PW]  = presc[c];
          end
          2'd1:    rd_data = load[c];
          2'd2:    rd_data = value[c];
          default: rd_data = 32'(pending[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready   <= 1'b0;
      data_o  <= '0;
      en      <= '0;
      mode    <= '0;
      ie      <= '0;
      pending <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        presc[c] <= '0;
        pc[c]    <= '0;
        load[c]  <= '0;
        value[c] <= '0;
      end
    end else begin
      ready <= access;
      if (access && (wstrb == 4'b0000)) data_o <= rd_data;
      for (int c = 0; c < CHANNELS; c++) begin
        // Bus write to CTRL wins over a one-shot self-disable in the same cycle.
        if (ctrl_wr[c]) begin
          en[c]    <= en_new[c];
          presc[c] <= presc_new[c];
          if (wstrb[0]) begin
            mode[c] <= data_i[1];
            ie[c]   <= data_i[2];
          end
        end else if (expire[c] && mode[c]) begin
          en[c] <= 1'b0;
        end

        if ((ctrl_wr[c] && (en_new[c] != en[c])) || value_wr[c] || tick[c])
          pc[c] <= '0;
        else if (en[c])
          pc[c] <= pc[c] + 1'b1;

        if (value_wr[c])
          value[c] <= merge(value[c], data_i, wstrb);
        else if (tick[c]) begin
          if (value[c] != 32'd0) value[c] <= value[c] - 32'd1;
          else if (!mode[c])     value[c] <= load[c];
        end

        if (load_wr[c]) load[c] <= merge(load[c], data_i, wstrb);

        if (expire[c])     pending[c] <= 1'b1;
        else if (clear[c]) pending[c] <= 1'b0;
      end
    end
  end

  assign irq     = pending & ie;
  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: register access, periodic/one-shot timing,
// byte lanes, collision cases, out-of-range decode and asynchronous reset.
module tb_timer_bank;

  logic        clk, reset_n, select;
  logic [3:0]  wstrb;
  logic [6:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic [3:0]  irq;
  logic        irq_any;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  timer_bank #(.CHANNELS(4), .PRESC_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .select(select), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o), .irq(irq), .irq_any(irq_any)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: one bus access, returns at the falling edge where ready is seen
  task automatic bus_xfer(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rdata, output int lat);
    @(negedge clk);
    addr = a; data_i = d; wstrb = s; select = 1'b1; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        break;
      end
    end
    rdata = data_o;
    select = 1'b0; wstrb = 4'b0000;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", data_o); end
    n_vec++; if (irq !== 4'h0) begin n_err++; $display("FAIL reset_irq got=%h exp=0", irq); end
    n_vec++; if (irq_any !== 1'b0) begin n_err++; $display("FAIL reset_irq_any got=%b exp=0", irq_any); end
    reset_n = 1'b1;
    for (int r = 0; r < 16; r++) exp_q.push_back(32'h0);
    for (int r = 0; r < 16; r++) begin
      bus_xfer(7'(r * 4), 32'h0, 4'b0000, rd, lat);
      n_vec++; if (rd !== exp_q.pop_front()) begin n_err++; $display("FAIL reset_regs addr=%h got=%h exp=0", r * 4, rd); end
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL reset_latency addr=%h got=%0d exp=1", r * 4, lat); end
    end
    n_vec++; if (irq !== 4'h0) begin n_err++; $display("FAIL reset_irq_after got=%h exp=0", irq); end
  endtask

  task automatic test_periodic();
    logic [31:0] rd;
    int lat;
    logic e;
    bus_xfer(7'h04, 32'd3, 4'hF, rd, lat);
    bus_xfer(7'h08, 32'd3, 4'hF, rd, lat);
    bus_xfer(7'h00, 32'h5, 4'hF, rd, lat);           // enable edge E
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = (k >= 4);
      n_vec++; if (irq[0] !== e) begin n_err++; $display("FAIL periodic_irq cyc=E+%0d got=%b exp=%b", k, irq[0], e); end
    end
    n_vec++; if (irq_any !== 1'b1) begin n_err++; $display("FAIL periodic_irq_any got=%b exp=1", irq_any); end
    repeat (2) @(negedge clk);                        // now after E+8
    bus_xfer(7'h0C, 32'h1, 4'b0001, rd, lat);         // clear at E+10
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL clear_latency got=%0d exp=1", lat); end
    n_vec++; if (irq[0] !== 1'b0) begin n_err++; $display("FAIL clear_drop got=%b exp=0", irq[0]); end
    for (int k = 11; k <= 12; k++) begin
      @(negedge clk);
      e = (k == 12);
      n_vec++; if (irq[0] !== e) begin n_err++; $display("FAIL periodic_rearm cyc=E+%0d got=%b exp=%b", k, irq[0], e); end
    end
    repeat (2) @(negedge clk);                        // now after E+14
    bus_xfer(7'h0C, 32'h1, 4'b0001, rd, lat);         // clear on expiry edge E+16
    n_vec++; if (irq[0] !== 1'b1) begin n_err++; $display("FAIL clear_collision_irq got=%b exp=1", irq[0]); end
    bus_xfer(7'h0C, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL clear_collision_status got=%h exp=1", rd); end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    int lat;
    logic e;
    bus_xfer(7'h24, 32'd9, 4'hF, rd, lat);
    bus_xfer(7'h28, 32'd9, 4'hF, rd, lat);
    bus_xfer(7'h20, 32'h0002_0007, 4'hF, rd, lat);   // enable edge G
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      e = (k >= 30);
      n_vec++; if (irq[2] !== e) begin n_err++; $display("FAIL oneshot_irq cyc=G+%0d got=%b exp=%b", k, irq[2], e); end
    end
    bus_xfer(7'h20, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0002_0006) begin n_err++; $display("FAIL oneshot_ctrl got=%h exp=00020006", rd); end
    bus_xfer(7'h28, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL oneshot_value got=%h exp=0", rd); end
    bus_xfer(7'h2C, 32'h1, 4'b0001, rd, lat);
    repeat (40) @(negedge clk);
    bus_xfer(7'h2C, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL oneshot_no_rearm got=%h exp=0", rd); end
    bus_xfer(7'h28, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL oneshot_value_hold got=%h exp=0", rd); end
    n_vec++; if (irq[2] !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_quiet got=%b exp=0", irq[2]); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    int lat;
    bus_xfer(7'h14, 32'h0, 4'hF, rd, lat);
    bus_xfer(7'h14, 32'hAABB_CCDD, 4'b0101, rd, lat);
    bus_xfer(7'h14, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h00BB_00DD) begin n_err++; $display("FAIL byte_lanes got=%h exp=00bb00dd", rd); end
    bus_xfer(7'h1C, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h00BB_00DD) begin n_err++; $display("FAIL data_hold got=%h exp=00bb00dd", rd); end
    bus_xfer(7'h18, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL load_keeps_value got=%h exp=0", rd); end
  endtask

  task automatic test_value_collision();
    logic [31:0] rd;
    int lat;
    bus_xfer(7'h34, 32'd100, 4'hF, rd, lat);
    bus_xfer(7'h38, 32'd50, 4'hF, rd, lat);
    bus_xfer(7'h30, 32'h0003_0001, 4'hF, rd, lat);   // enable edge F, ticks at F+4, F+8
    repeat (6) @(negedge clk);
    bus_xfer(7'h38, 32'd7, 4'hF, rd, lat);            // write lands on tick edge F+8
    bus_xfer(7'h38, 32'h0, 4'b0000, rd, lat);         // F+10
    n_vec++; if (rd !== 32'd7) begin n_err++; $display("FAIL value_collision got=%0d exp=7", rd); end
    bus_xfer(7'h38, 32'h0, 4'b0000, rd, lat);         // F+12, pre-tick value
    n_vec++; if (rd !== 32'd7) begin n_err++; $display("FAIL value_pre_tick got=%0d exp=7", rd); end
    bus_xfer(7'h38, 32'h0, 4'b0000, rd, lat);         // F+14
    n_vec++; if (rd !== 32'd6) begin n_err++; $display("FAIL value_post_tick got=%0d exp=6", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int lat;
    bus_xfer(7'h40, 32'hFFFF_FFFF, 4'hF, rd, lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL oor_ready got=%0d exp=1", lat); end
    bus_xfer(7'h40, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL oor_read got=%h exp=0", rd); end
    bus_xfer(7'h7C, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL oor_read_top got=%h exp=0", rd); end
    bus_xfer(7'h14, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h00BB_00DD) begin n_err++; $display("FAIL oor_ch1_load got=%h exp=00bb00dd", rd); end
    bus_xfer(7'h04, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'd3) begin n_err++; $display("FAIL oor_ch0_load got=%h exp=3", rd); end
    bus_xfer(7'h34, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'd100) begin n_err++; $display("FAIL oor_ch3_load got=%h exp=64", rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    int lat;
    bus_xfer(7'h00, 32'h0, 4'b0000, rd, lat);         // ready high, data_o=5, ch0 pending
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL areset_ready got=%b exp=0", ready); end
    n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL areset_data got=%h exp=0", data_o); end
    n_vec++; if (irq !== 4'h0) begin n_err++; $display("FAIL areset_irq got=%h exp=0", irq); end
    n_vec++; if (irq_any !== 1'b0) begin n_err++; $display("FAIL areset_irq_any got=%b exp=0", irq_any); end
    @(negedge clk);
    reset_n = 1'b1;
    bus_xfer(7'h00, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL areset_ctrl got=%h exp=0", rd); end
    bus_xfer(7'h08, 32'h0, 4'b0000, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL areset_value got=%h exp=0", rd); end
  endtask

  initial begin
    reset_n = 1'b0; select = 1'b0; wstrb = 4'b0000; addr = '0; data_i = '0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_byte_lanes();
    test_value_collision();
    test_out_of_range();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel memory-mapped timer, the successor to the single-channel `systick`. It sits on the picorv32 native memory bus behind the top-level address decoder, exactly where `systick` sits today. It provides CHANNELS independent 32-bit down-counters. Each channel has its own prescaler, periodic or one-shot mode, a sticky pending flag and a per-channel interrupt line to the CPU `irq` vector.

## Interface
- CHANNELS, 4, number of timer channels, legal range 1..8.
- PRESC_WIDTH, 16, width of each channel's prescaler divide field and counter, legal range 1..16.

Reset is asynchronous and active-low; there is one clock.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- select  in  1  bus select; held high while the decoded CPU access is pending.
- wstrb  in  4  byte write strobes; 0000 means a read.
- addr  in  7  byte offset; addr[6:4] selects the channel, addr[3:2] selects the register.
- data_i  in  32  write data.
- ready  out  1  access-complete pulse.
- data_o  out  32  read data.
- irq  out  CHANNELS  per-channel interrupt, equal to pending & IE.
- irq_any  out  1  OR of all bits of irq.

## Operation
Register map per channel, at base = channel*0x10:
- 0x0 CTRL: bit0 EN, bit1 MODE (0 = periodic, 1 = one-shot), bit2 IE, bits[16+PRESC_WIDTH-1:16] PRESC. All other bits read 0.
- 0x4 LOAD: 32-bit reload value.
- 0x8 VALUE: current count. A write sets the count directly.
- 0xC STATUS: bit0 PENDING. Writing 1 to bit0 with wstrb[0] set clears it. Writing 0 has no effect.

Bus access:
- Writes honour byte lanes via wstrb.
- Addresses whose channel index is >= CHANNELS read 0, ignore writes, and still return ready.

Per-channel counting, when EN=1:
- A prescaler counter pc counts 0..PRESC. A tick occurs in a cycle where pc == PRESC; pc then returns to 0. PRESC=0 gives a tick every cycle.
- On a tick with VALUE != 0, VALUE decrements by 1.
- On a tick with VALUE == 0 (expiry), PENDING is set.
  - Periodic mode: VALUE reloads from LOAD.
  - One-shot mode: EN clears and VALUE stays 0.
- Expiry period is (LOAD+1)*(PRESC+1) cycles. LOAD=0 in periodic mode expires on every tick.
- VALUE never wraps below 0.

EN=0: VALUE and pc hold.

Events that reset pc to 0: any CTRL write that changes EN, and any VALUE write.

Writing LOAD never alters VALUE.

Simultaneous events:
- A bus write to VALUE and a tick in the same cycle: the bus write wins; no decrement and no expiry.
- A STATUS clear and an expiry in the same cycle: PENDING remains 1.
- A CTRL write setting EN=1 and a one-shot expiry in the same cycle: the bus write wins and EN=1.

## Timing
- Reset values: ready=0, data_o=0, irq=0, irq_any=0. CTRL, LOAD, VALUE, PENDING and pc are all 0.
- Assertion of reset_n low clears all state immediately, including mid-access and mid-count.
- Access rule: at a rising edge with select=1 and ready=0, the access is performed. Write data commits at that edge, data_o is registered, and ready is set to 1.
- At the next edge ready returns to 0 unconditionally. ready is therefore high for exactly 1 cycle per access, with 1-cycle latency.
- data_o is valid while ready=1. It holds that value afterwards until the next read.
- A read of VALUE returns the count before that edge's update.
- PENDING, irq and irq_any change at the edge where expiry occurs. irq is a pure function of registered state and has no combinational path from the bus.
- A STATUS clear drops irq at the same edge that asserts ready.
- A select that stays high across cycles produces one access per ready pulse. The CPU drops select after ready, so no duplicate access is generated.

## Test plan
- Reset then read all 16 registers of CHANNELS=4 -> every read returns 0 with ready high exactly 1 cycle after select; irq=0.
- Ch0 periodic: LOAD=3, PRESC=0, CTRL=0x5 -> PENDING sets every 4 cycles and irq[0]=1. Write STATUS=1 -> irq[0] drops at the ready edge and re-asserts 4 cycles after the last expiry.
- Ch2 one-shot: LOAD=9, PRESC=2, CTRL=0x7 -> expiry 30 cycles after enable. CTRL then reads 0x6, VALUE stays 0, and no further expiries occur.
- Byte lanes: write 0xAABBCCDD to ch1 LOAD with wstrb=0101 after LOAD=0 -> read returns 0x00BB00DD.
- Collision: STATUS clear issued on the exact expiry cycle -> PENDING reads 1. A VALUE write of 7 on a tick cycle -> VALUE reads 7, not 6.
- Out-of-range: write to addr 0x40 with CHANNELS=4 -> ready pulses and no channel changes; reading 0x40 returns 0. Assert reset_n low mid-count -> all outputs 0 immediately.
